// File: rtl/servant_irq_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | servant_irq_pkg : register map and limits for servant_irq_ctrl    |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
package servant_irq_pkg;

  localparam logic [1:0] REG_PENDING = 2'd0;
  localparam logic [1:0] REG_ENABLE  = 2'd1;
  localparam logic [1:0] REG_EDGE    = 2'd2;
  localparam logic [1:0] REG_CLAIM   = 2'd3;

  localparam int MAX_SRC = 31;

endpackage
`default_nettype wire

// File: rtl/servant_irq_sync.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | servant_irq_sync : per-source synchroniser with rise detection    |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
module servant_irq_sync
  import servant_irq_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic wb_clk,
  input  logic wb_rst_n,
  input  logic i_src,
  output logic o_s,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_src};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_s    = r_sync[SYNC_STAGES-1];
  assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/servant_irq_ctrl.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | servant_irq_ctrl : edge/level interrupt controller, Wishbone slave |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
module servant_irq_ctrl
  import servant_irq_pkg::*;
#(
  parameter int NUM_SRC     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               wb_clk,
  input  logic               wb_rst_n,
  input  logic [NUM_SRC-1:0] i_src,
  input  logic [1:0]         i_wb_adr,
  input  logic [31:0]        i_wb_dat,
  input  logic [3:0]         i_wb_sel,
  input  logic               i_wb_we,
  input  logic               i_wb_cyc,
  output logic [31:0]        o_wb_rdt,
  output logic               o_wb_ack,
  output logic               o_irq
);

  localparam int ID_W = $clog2(MAX_SRC + 1);

  logic [NUM_SRC-1:0] w_s;
  logic [NUM_SRC-1:0] w_rise;
  logic [NUM_SRC-1:0] r_pending;
  logic [NUM_SRC-1:0] r_enable;
  logic [NUM_SRC-1:0] r_edge;
  logic [NUM_SRC-1:0] w_active;
  logic [NUM_SRC-1:0] w_wmask;
  logic [NUM_SRC-1:0] w_wbits;
  logic [NUM_SRC-1:0] w_clr;
  logic [NUM_SRC-1:0] w_pending_nxt;
  logic               w_access;
  logic               w_wr;
  logic               w_claim_rd;
  logic [ID_W-1:0]    w_claim_id;
  logic [31:0]        w_rdata;
  logic               r_ack;
  logic [31:0]        r_rdt;
  logic               r_irq;
  logic               w_unused;

  function automatic logic [ID_W-1:0] f_lowest_id(input logic [NUM_SRC-1:0] v);
    logic [ID_W-1:0] id;
    id = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (v[k]) id = ID_W'(k + 1);
    end
    return id;
  endfunction

  generate
    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
      servant_irq_sync #(
        .SYNC_STAGES (SYNC_STAGES)
      ) u_sync (
        .wb_clk   (wb_clk),
        .wb_rst_n (wb_rst_n),
        .i_src    (i_src[k]),
        .o_s      (w_s[k]),
        .o_rise   (w_rise[k])
      );
      // Byte-lane gating; only lanes that overlap implemented sources matter.
      assign w_wmask[k] = i_wb_sel[k/8];
      assign w_wbits[k] = i_wb_dat[k] & i_wb_sel[k/8];
    end
  endgenerate

  assign w_unused   = ^{i_wb_dat, i_wb_sel};
  assign w_access   = i_wb_cyc & ~r_ack;
  assign w_wr       = w_access & i_wb_we;
  assign w_claim_rd = w_access & ~i_wb_we & (i_wb_adr == REG_CLAIM);
  assign w_active   = r_pending & r_enable;
  assign w_claim_id = f_lowest_id(w_active);

  always_comb begin
    w_clr = '0;
    if (w_wr && (i_wb_adr == REG_PENDING)) w_clr = w_wbits;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (w_claim_rd && (w_claim_id == ID_W'(k + 1))) w_clr[k] = 1'b1;
    end
  end

  // Edge bits: a same-cycle rise beats any clear. Level bits just follow s.
  assign w_pending_nxt = (r_edge & (w_rise | (r_pending & ~w_clr))) | (~r_edge & w_s);

  always_comb begin
    w_rdata = '0;
    case (i_wb_adr)
      REG_PENDING: w_rdata = 32'(r_pending);
      REG_ENABLE:  w_rdata = 32'(r_enable);
      REG_EDGE:    w_rdata = 32'(r_edge);
      default:     w_rdata = 32'(w_claim_id);
    endcase
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_pending <= '0;
      r_enable  <= '0;
      r_edge    <= '0;
      r_ack     <= 1'b0;
      r_rdt     <= '0;
      r_irq     <= 1'b0;
    end else begin
      r_pending <= w_pending_nxt;
      r_irq     <= |w_active;
      r_ack     <= w_access;
      r_rdt     <= w_access ? w_rdata : 32'd0;
      if (w_wr && (i_wb_adr == REG_ENABLE)) r_enable <= (r_enable & ~w_wmask) | w_wbits;
      if (w_wr && (i_wb_adr == REG_EDGE))   r_edge   <= (r_edge & ~w_wmask) | w_wbits;
    end
  end

  assign o_wb_ack = r_ack;
  assign o_wb_rdt = r_rdt;
  assign o_irq    = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_servant_irq_ctrl.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | tb_servant_irq_ctrl : scoreboard bench with behavioural model     |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
module tb_servant_irq_ctrl;

  localparam int N  = 8;
  localparam int SS = 2;

  typedef struct {
    logic        chk;
    logic [31:0] rdt;
  } exp_t;

  logic          wb_clk   = 1'b0;
  logic          wb_rst_n = 1'b0;
  logic [N-1:0]  i_src    = '0;
  logic [1:0]    i_wb_adr = '0;
  logic [31:0]   i_wb_dat = '0;
  logic [3:0]    i_wb_sel = '0;
  logic          i_wb_we  = 1'b0;
  logic          i_wb_cyc = 1'b0;
  logic [31:0]   o_wb_rdt;
  logic          o_wb_ack;
  logic          o_irq;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t exp_q[$];

  // Reference state: register contents plus a history of raw source samples.
  logic [N-1:0] m_pend, m_en, m_edge;
  logic         m_irq, m_ack;
  logic [N-1:0] m_hist [0:SS];

  servant_irq_ctrl #(.NUM_SRC(N), .SYNC_STAGES(SS)) dut (
    .wb_clk   (wb_clk),
    .wb_rst_n (wb_rst_n),
    .i_src    (i_src),
    .i_wb_adr (i_wb_adr),
    .i_wb_dat (i_wb_dat),
    .i_wb_sel (i_wb_sel),
    .i_wb_we  (i_wb_we),
    .i_wb_cyc (i_wb_cyc),
    .o_wb_rdt (o_wb_rdt),
    .o_wb_ack (o_wb_ack),
    .o_irq    (o_irq)
  );

  always #5 wb_clk = ~wb_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge wb_clk or negedge wb_rst_n) begin : model
    logic [N-1:0] s, p, clr, mk, wv;
    logic         acc;
    int           id;
    logic [31:0]  rd;
    if (!wb_rst_n) begin
      m_pend <= '0;
      m_en   <= '0;
      m_edge <= '0;
      m_irq  <= 1'b0;
      m_ack  <= 1'b0;
      for (int k = 0; k <= SS; k++) m_hist[k] <= '0;
    end else begin
      s   = m_hist[SS-1];
      p   = m_hist[SS];
      acc = i_wb_cyc && !m_ack;
      id  = 0;
      for (int k = 0; k < N; k++)
        if (m_pend[k] && m_en[k] && id == 0) id = k + 1;
      clr = '0;
      for (int k = 0; k < N; k++) begin
        mk[k] = i_wb_sel[k/8];
        wv[k] = i_wb_dat[k] & mk[k];
      end
      if (acc) begin
        case (i_wb_adr)
          2'd0:    rd = {24'd0, m_pend};
          2'd1:    rd = {24'd0, m_en};
          2'd2:    rd = {24'd0, m_edge};
          default: rd = 32'(id);
        endcase
        exp_q.push_back('{chk: !i_wb_we, rdt: rd});
        if (i_wb_we) begin
          if (i_wb_adr == 2'd0) clr = wv;
          if (i_wb_adr == 2'd1) m_en   <= (m_en & ~mk) | wv;
          if (i_wb_adr == 2'd2) m_edge <= (m_edge & ~mk) | wv;
        end else if (i_wb_adr == 2'd3 && id != 0) begin
          clr[id-1] = 1'b1;
        end
      end
      for (int k = 0; k < N; k++)
        m_pend[k] <= m_edge[k] ? ((s[k] && !p[k]) || (m_pend[k] && !clr[k])) : s[k];
      m_irq <= |(m_pend & m_en);
      m_ack <= acc;
      m_hist[0] <= i_src;
      for (int k = 1; k <= SS; k++) m_hist[k] <= m_hist[k-1];
    end
  end

  always @(negedge wb_clk) begin : monitor
    exp_t e;
    if (wb_rst_n) begin
      chk("irq", {31'd0, o_irq}, {31'd0, m_irq});
      chk("ack", {31'd0, o_wb_ack}, {31'd0, m_ack});
      if (o_wb_ack) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_ack", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          if (e.chk) chk("rdt", o_wb_rdt, e.rdt);
        end
      end else begin
        chk("rdt_idle", o_wb_rdt, 32'd0);
      end
    end
  end

  task automatic bus(input logic [1:0] a, input logic w, input logic [31:0] d, input logic [3:0] s);
    @(negedge wb_clk);
    i_wb_adr = a;
    i_wb_we  = w;
    i_wb_dat = d;
    i_wb_sel = s;
    i_wb_cyc = 1'b1;
    @(negedge wb_clk);
    i_wb_cyc = 1'b0;
    i_wb_we  = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a);
    bus(a, 1'b0, 32'd0, 4'h0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus(a, 1'b1, d, 4'hF);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge wb_clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(3);
    wb_rst_n = 1'b1;

    // Reset state
    for (int a = 0; a < 4; a++) rd(2'(a));

    // Edge mode pulse on source 0, then claim
    wr(2'd2, 32'h01);
    wr(2'd1, 32'h01);
    @(negedge wb_clk) i_src[0] = 1'b1;
    @(negedge wb_clk) i_src[0] = 1'b0;
    idle(4);
    rd(2'd3);
    idle(2);
    rd(2'd0);

    // Level mode on source 3
    wr(2'd2, 32'h00);
    wr(2'd1, 32'h08);
    i_src[3] = 1'b1;
    idle(4);
    rd(2'd3);
    rd(2'd0);
    i_src[3] = 1'b0;
    idle(5);
    rd(2'd0);

    // Clear collides with a synchronised rise on source 1
    wr(2'd2, 32'h02);
    wr(2'd1, 32'h02);
    @(negedge wb_clk) i_src[1] = 1'b1;
    @(negedge wb_clk);
    wr(2'd0, 32'h02);
    rd(2'd0);
    i_src[1] = 1'b0;
    wr(2'd0, 32'h02);
    rd(2'd0);

    // Two edge sources, priority claim order
    wr(2'd2, 32'h24);
    wr(2'd1, 32'h24);
    @(negedge wb_clk) i_src = 8'h24;
    @(negedge wb_clk) i_src = 8'h00;
    idle(4);
    rd(2'd3);
    rd(2'd3);
    rd(2'd3);

    // Byte lane above implemented sources
    wr(2'd1, 32'h00);
    bus(2'd1, 1'b1, 32'hFFFF_FFFF, 4'b0010);
    rd(2'd1);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       @(negedge wb_clk) i_src = N'($urandom);
        1:       idle($urandom_range(1, 3));
        default: bus(2'($urandom), 1'($urandom), $urandom, 4'($urandom));
      endcase
    end

    // Reset asserted while an ack is on the bus
    i_src = '0;
    wr(2'd1, 32'hA5);
    wr(2'd2, 32'h5A);
    @(negedge wb_clk);
    i_wb_adr = 2'd1;
    i_wb_we  = 1'b0;
    i_wb_cyc = 1'b1;
    @(posedge wb_clk);
    #2;
    chk("ack_before_rst", {31'd0, o_wb_ack}, 32'd1);
    wb_rst_n = 1'b0;
    #1;
    chk("ack_async_rst", {31'd0, o_wb_ack}, 32'd0);
    exp_q.delete();
    i_wb_cyc = 1'b0;
    idle(2);
    wb_rst_n = 1'b1;
    for (int a = 0; a < 4; a++) rd(2'(a));

    idle(3);
    chk("sb_drain", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
